// File: rtl/spi_slave_shift_engine.sv
`timescale 1ns/1ps
// spi_slave_shift_engine
//   SPI slave serializer/deserializer. sclk, cs_n and mosi0 are oversampled
//   in the pclk domain. Supports all four CPOL/CPHA modes, MSB/LSB-first
//   ordering and back-to-back words while cs_n stays low.
//
//   Optional feature macro: SPI_SLAVE_IN_SYNC_EN adds a two-flop synchronizer
//   ahead of the input register (pin latencies +2 pclk, sclk period >= 6 pclk).
//   Without it, sclk period must be >= 4 pclk.
//
// Ports:
//   pclk, areset          clock, synchronous active-high reset
//   cs_n, sclk, mosi0     SPI pins (inputs)
//   miso0, miso_oe        SPI slave data out and its output enable
//   cpol, cpha, lsb_first mode configuration, latched at cs_n assertion
//   tx_data/valid/ready   transmit word handshake (tx_ready = consume pulse)
//   rx_data/valid/ready   receive word handshake (rx_valid held until ready)
//   tx_underrun           sticky: word load with tx_valid low
//   rx_overrun            sticky: word done while rx_valid && !rx_ready
//   clr_err               clears both sticky flags (wins over a same-cycle set)
module spi_slave_shift_engine #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_W      = $clog2(DATA_WIDTH + 1)
) (
    input  logic                  pclk,
    input  logic                  areset,
    input  logic                  cs_n,
    input  logic                  sclk,
    input  logic                  mosi0,
    output logic                  miso0,
    output logic                  miso_oe,
    input  logic                  cpol,
    input  logic                  cpha,
    input  logic                  lsb_first,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  tx_underrun,
    output logic                  rx_overrun,
    input  logic                  clr_err
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic {
        ST_IDLE,
        ST_ACTIVE
    } state_t;

    state_t state, state_nxt;

    // ------------------------------------------------------------------
    // Input stage
    // ------------------------------------------------------------------
    logic [2:0] pins_in;

`ifdef SPI_SLAVE_IN_SYNC_EN
    logic [2:0] sync1, sync2;

    always_ff @(posedge pclk) begin
        if (areset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {sclk, cs_n, mosi0};
            sync2 <= sync1;
        end
    end

    assign pins_in = sync2;
`else
    assign pins_in = {sclk, cs_n, mosi0};
`endif

    logic sclk_q, cs_n_q, mosi_q;
    logic sclk_prev, cs_prev;
    logic sclk_rise_r, sclk_fall_r, cs_fall_r, cs_rise_r, mosi_r;

    // Edge pulses are registered; mosi_r is delayed alongside so the
    // captured bit lines up with the sclk sample that produced the pulse.
    always_ff @(posedge pclk) begin
        if (areset) begin
            sclk_q      <= 1'b0;
            cs_n_q      <= 1'b0;
            mosi_q      <= 1'b0;
            sclk_prev   <= 1'b0;
            cs_prev     <= 1'b0;
            sclk_rise_r <= 1'b0;
            sclk_fall_r <= 1'b0;
            cs_fall_r   <= 1'b0;
            cs_rise_r   <= 1'b0;
            mosi_r      <= 1'b0;
        end else begin
            {sclk_q, cs_n_q, mosi_q} <= pins_in;
            sclk_prev   <= sclk_q;
            cs_prev     <= cs_n_q;
            sclk_rise_r <= sclk_q & ~sclk_prev;
            sclk_fall_r <= ~sclk_q & sclk_prev;
            cs_fall_r   <= ~cs_n_q & cs_prev;
            cs_rise_r   <= cs_n_q & ~cs_prev;
            mosi_r      <= mosi_q;
        end
    end

    // ------------------------------------------------------------------
    // Latched configuration and datapath state
    // ------------------------------------------------------------------
    logic                  cpol_l, cpha_l, lsb_l;
    logic [DATA_WIDTH-1:0] tx_sr, rx_sr, rx_next;
    logic [CNT_W-1:0]      bit_cnt;
    logic                  skip_drive;

    logic lead_e, trail_e;
    logic do_load, sample_en, drive_en, word_done;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge pclk) begin
        if (areset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state, datapath strobes and outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        do_load   = 1'b0;
        sample_en = 1'b0;
        drive_en  = 1'b0;
        word_done = 1'b0;
        miso_oe   = 1'b0;
        miso0     = 1'b0;
        tx_ready  = 1'b0;

        lead_e  = cpol_l ? sclk_fall_r : sclk_rise_r;
        trail_e = cpol_l ? sclk_rise_r : sclk_fall_r;

        case (state)
            ST_IDLE: begin
                if (cs_fall_r) begin
                    state_nxt = ST_ACTIVE;
                    do_load   = 1'b1;
                end
            end
            ST_ACTIVE: begin
                miso_oe = 1'b1;
                miso0   = lsb_l ? tx_sr[0] : tx_sr[DATA_WIDTH-1];
                // Deselect takes priority over a coincident sclk edge.
                if (cs_rise_r) begin
                    state_nxt = ST_IDLE;
                end else begin
                    sample_en = cpha_l ? trail_e : lead_e;
                    drive_en  = cpha_l ? lead_e : trail_e;
                    if (sample_en && (bit_cnt == LAST_BIT)) begin
                        word_done = 1'b1;
                        do_load   = 1'b1;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        tx_ready = do_load & tx_valid;
    end

    always_comb begin
        rx_next = '0;
        if (lsb_l) begin
            rx_next = {mosi_r, rx_sr[DATA_WIDTH-1:1]};
        end else begin
            rx_next = {rx_sr[DATA_WIDTH-2:0], mosi_r};
        end
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    // skip_drive suppresses the first drive edge after a load whenever that
    // edge would otherwise shift out bit 0 before the master has sampled it:
    // after a cs_n-fall load with cpha=1, and after every back-to-back load.
    always_ff @(posedge pclk) begin
        if (areset) begin
            cpol_l      <= 1'b0;
            cpha_l      <= 1'b0;
            lsb_l       <= 1'b0;
            tx_sr       <= '0;
            rx_sr       <= '0;
            bit_cnt     <= '0;
            skip_drive  <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            rx_overrun  <= 1'b0;
        end else begin
            if ((state == ST_IDLE) && cs_fall_r) begin
                cpol_l  <= cpol;
                cpha_l  <= cpha;
                lsb_l   <= lsb_first;
                bit_cnt <= '0;
                rx_sr   <= '0;
            end

            if (do_load) begin
                tx_sr      <= tx_valid ? tx_data : '0;
                skip_drive <= (state == ST_IDLE) ? cpha : 1'b1;
            end else if (drive_en) begin
                if (skip_drive) begin
                    skip_drive <= 1'b0;
                end else if (lsb_l) begin
                    tx_sr <= {1'b0, tx_sr[DATA_WIDTH-1:1]};
                end else begin
                    tx_sr <= {tx_sr[DATA_WIDTH-2:0], 1'b0};
                end
            end

            if (sample_en) begin
                rx_sr   <= rx_next;
                bit_cnt <= word_done ? '0 : bit_cnt + CNT_W'(1);
            end

            if (word_done) begin
                rx_data  <= rx_next;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end

            if (clr_err) begin
                tx_underrun <= 1'b0;
            end else if (do_load && !tx_valid) begin
                tx_underrun <= 1'b1;
            end

            if (clr_err) begin
                rx_overrun <= 1'b0;
            end else if (word_done && rx_valid && !rx_ready) begin
                rx_overrun <= 1'b1;
            end
        end
    end

endmodule
